fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, meaning the number of requester streams sharing one FIFO write port (legal range 2..16).
REQ-002 The block SHALL have parameter ElemWidth, default 8, meaning the element width in bits.
REQ-003 The block SHALL have parameter MaxBurst, default 4, meaning the maximum number of elements accepted per grant (legal range 1..255).
REQ-004 clk_i  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 srst_ni  input  1  reset, synchronous, active-low: sampled on the rising edge of clk_i.
REQ-006 elem_in_i  input  NumReq*ElemWidth  requester data; requester k occupies bits [k*ElemWidth +: ElemWidth].
REQ-007 elem_in_valid_i  input  NumReq  per-requester valid.
REQ-008 elem_in_ready_o  output  NumReq  per-requester ready; at most one bit high in any cycle.
REQ-009 elem_out_o  output  ElemWidth  registered data towards the FIFO write side.
REQ-010 elem_out_valid_o  output  1  registered valid towards the FIFO.
REQ-011 elem_out_ready_i  input  1  FIFO ready (fifo elem_in_ready_o).
REQ-012 grant_id_o  output  max(1,$clog2(NumReq))  index of the current or last granted requester.
REQ-013 busy_o  output  1  high while the state is GRANT.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-015 In IDLE, all elem_in_ready_o bits SHALL be low.
REQ-016 In IDLE, when any elem_in_valid_i bit is high, the block SHALL select the first valid index found by searching from rr_ptr upward, modulo NumReq; it SHALL load grant_id_o with that index, clear burst_cnt and enter GRANT on the next edge.
REQ-017 In IDLE with no valid bits, the FSM SHALL remain in IDLE and all registers SHALL hold.
REQ-018 In GRANT, elem_in_ready_o[grant_id_o] SHALL equal (~elem_out_valid_o | elem_out_ready_i), and all other ready bits SHALL be low.
REQ-019 An input handshake SHALL be counted when the granted requester's valid and ready are both high; on that edge the block SHALL load the element into elem_out_o, set elem_out_valid_o and increment burst_cnt.
REQ-020 An output handshake (elem_out_valid_o & elem_out_ready_i) without a simultaneous input handshake SHALL clear elem_out_valid_o; with a simultaneous input handshake elem_out_valid_o SHALL stay high and elem_out_o SHALL take the new data.
REQ-021 elem_out_o and elem_out_valid_o SHALL hold while elem_out_valid_o=1 and elem_out_ready_i=0.
REQ-022 The block SHALL release the grant, on the next edge, when an input handshake occurs with burst_cnt==MaxBurst-1.
REQ-023 The block SHALL also release the grant, on the next edge, when the granted requester's elem_in_valid_i is low in a GRANT cycle; this includes the first GRANT cycle.
REQ-024 On release the FSM SHALL enter IDLE and rr_ptr SHALL become (grant_id_o+1) mod NumReq; grant_id_o SHALL hold its value.
REQ-025 A granted requester stalled by a full FIFO (ready low, valid high) SHALL keep the grant indefinitely, and burst_cnt SHALL not advance.
REQ-026 Latency: a valid rising in IDLE at edge N SHALL produce a ready at cycle N+1 and elem_out_valid_o at N+2 (if the FIFO is ready); each grant costs exactly one IDLE bubble cycle.
REQ-027 Element order within a requester SHALL be preserved; no element SHALL be dropped or duplicated.
REQ-028 Fairness: with all NumReq requesters continuously valid, grants SHALL rotate 0,1,..,NumReq-1,0,..., each receiving exactly MaxBurst elements.
REQ-029 burst_cnt SHALL be ceil($clog2(MaxBurst+1)) bits wide and SHALL never exceed MaxBurst-1 at a clock edge.

Reset
REQ-030 While srst_ni=0 at a rising edge, the block SHALL set state=IDLE, rr_ptr=0, burst_cnt=0, grant_id_o=0, elem_out_o=0 and elem_out_valid_o=0; busy_o and elem_in_ready_o SHALL then be 0.
REQ-031 A reset asserted mid-burst SHALL discard any pending element in the output register, with no element output after reset, and arbitration SHALL restart from requester 0.
REQ-032 Inputs SHALL be ignored during any cycle in which srst_ni=0.

Verification
REQ-033 Reset: drive srst_ni=0 for 2 cycles with all valids high -> all outputs 0; the first grant after release of reset goes to requester 0.
REQ-034 Round-robin: NumReq=4, MaxBurst=4, all valid, FIFO always ready -> grant sequence 0,1,2,3,0 with 4 elements each and a one-cycle bubble between grants.
REQ-035 Early release: requester 2 presents only 2 elements while requesters 0..3 are all valid -> requester 2 is released after 2 elements and the next grant goes to 3.
REQ-036 Backpressure: downstream is a Depth=8 fifo with its read side idle -> exactly 8 elements are accepted, then all ready bits stay low and grant_id_o is stable; on enabling reads, the flow resumes with no loss.
REQ-037 Mid-burst reset: assert srst_ni=0 after the 2nd element of a grant to requester 1 -> elem_out_valid_o=0 on the next edge and the next grant goes to 0.
REQ-038 Random: 4 requesters with random valid (50%) and random FIFO ready (70%) over 1000 elements -> per-requester scoreboard ordering is correct, error count is 0, and no requester is starved for more than 3*(MaxBurst+1) consecutive grant slots.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter funnelling NumReq requester streams into one FIFO write port.
// Each grant accepts up to MaxBurst elements, then arbitration moves past the winner.
module fifo_rr_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned ElemWidth = 8,
    parameter int unsigned MaxBurst  = 4,
    localparam int unsigned IdW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        srst_ni,
    input  logic [NumReq*ElemWidth-1:0] elem_in_i,
    input  logic [NumReq-1:0]           elem_in_valid_i,
    output logic [NumReq-1:0]           elem_in_ready_o,
    output logic [ElemWidth-1:0]        elem_out_o,
    output logic                        elem_out_valid_o,
    input  logic                        elem_out_ready_i,
    output logic [IdW-1:0]              grant_id_o,
    output logic                        busy_o
);

    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [CntW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [ElemWidth-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;

    logic [2*NumReq-1:0]  valid_dbl;
    logic [NumReq-1:0]    valid_rot;
    logic                 any_valid;
    logic [IdW:0]         pick_sum;
    logic [IdW-1:0]       pick_id;
    logic                 gnt_valid;
    logic [ElemWidth-1:0] gnt_data;
    logic                 slot_free;
    logic                 in_hs;
    logic                 out_hs;
    logic                 last_beat;

    // Rotate valids so index 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        valid_dbl = {elem_in_valid_i, elem_in_valid_i};
        valid_rot = valid_dbl[rr_ptr_q +: NumReq];
        any_valid = |valid_rot;
        pick_sum  = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                pick_sum = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
            end
        end
        if (pick_sum >= (IdW + 1)'(NumReq)) begin
            pick_sum = pick_sum - (IdW + 1)'(NumReq);
        end
        pick_id = pick_sum[IdW-1:0];
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (grant_id_q == IdW'(k)) begin
                gnt_valid = elem_in_valid_i[k];
                gnt_data  = elem_in_i[k*ElemWidth +: ElemWidth];
            end
        end
    end

    always_comb begin
        slot_free = ~out_valid_q | elem_out_ready_i;
        in_hs     = (state_q == StGrant) & gnt_valid & slot_free;
        out_hs    = out_valid_q & elem_out_ready_i;
        last_beat = (burst_cnt_q == CntW'(MaxBurst - 1));
    end

    always_comb begin
        elem_in_ready_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            elem_in_ready_o[k] = (state_q == StGrant) && (grant_id_q == IdW'(k)) && slot_free;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d     = StGrant;
                    grant_id_d  = pick_id;
                    burst_cnt_d = '0;
                end
            end
            StGrant: begin
                // A stalled requester (valid high, slot busy) keeps the grant.
                if (!gnt_valid || (in_hs && last_beat)) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_id_q == IdW'(NumReq - 1)) ? '0 : grant_id_q + 1'b1;
                end
                if (in_hs) begin
                    burst_cnt_d = last_beat ? '0 : burst_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_hs) begin
            out_data_d  = gnt_data;
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign elem_out_o       = out_data_q;
    assign elem_out_valid_o = out_valid_q;
    assign grant_id_o       = grant_id_q;
    assign busy_o           = (state_q == StGrant);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed and random bench for fifo_rr_arbiter with an in-order scoreboard of accepted elements.
module tb_fifo_rr_arbiter;

    localparam int NR = 4;
    localparam int EW = 8;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             srst_ni;
    logic [NR*EW-1:0] elem_in_i;
    logic [NR-1:0]    elem_in_valid_i;
    logic [NR-1:0]    elem_in_ready_o;
    logic [EW-1:0]    elem_out_o;
    logic             elem_out_valid_o;
    logic             elem_out_ready_i;
    logic [1:0]       grant_id_o;
    logic             busy_o;

    fifo_rr_arbiter #(
        .NumReq    (NR),
        .ElemWidth (EW),
        .MaxBurst  (MB)
    ) dut (
        .clk_i            (clk),
        .srst_ni          (srst_ni),
        .elem_in_i        (elem_in_i),
        .elem_in_valid_i  (elem_in_valid_i),
        .elem_in_ready_o  (elem_in_ready_o),
        .elem_out_o       (elem_out_o),
        .elem_out_valid_o (elem_out_valid_o),
        .elem_out_ready_i (elem_out_ready_i),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    int            hs_req[$];
    int            hs_cyc[$];
    int            cyc = 0;
    int            out_cnt = 0;
    logic [5:0]    seq [NR];
    int            left [NR];
    bit            en [NR];
    int            vld_pct = 100;
    int            rdy_pct = 100;
    bit            fifo_mode = 1'b0;
    bit            rd_en = 1'b0;
    int            fifo_cnt = 0;
    int            skip [NR];
    int            max_skip = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample at negedge+1, record handshakes, advance.
    task automatic cycle();
        logic [NR-1:0] vld;
        logic [NR-1:0] in_hs;
        logic          out_hs;
        logic          dec;
        logic [NR-1:0] dec_vld;
        int            cnt0;
        for (int k = 0; k < NR; k++) begin
            vld[k] = en[k] && (left[k] != 0) && ($urandom_range(99) < vld_pct);
            elem_in_i[k*EW +: EW] = {2'(k), seq[k]};
        end
        elem_in_valid_i = vld;
        cnt0 = fifo_cnt;
        if (!srst_ni) elem_out_ready_i = 1'b0;
        else if (fifo_mode) elem_out_ready_i = (fifo_cnt < 8);
        else elem_out_ready_i = ($urandom_range(99) < rdy_pct);
        #1;
        chk("ready_onehot", 32'($onehot0(elem_in_ready_o)), 32'd1);
        in_hs  = srst_ni ? (elem_in_valid_i & elem_in_ready_o) : '0;
        out_hs = srst_ni && elem_out_valid_o && elem_out_ready_i;
        dec     = srst_ni && !busy_o && (|elem_in_valid_i);
        dec_vld = elem_in_valid_i;
        if (out_hs) begin
            chk("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_data", 32'(elem_out_o), 32'(exp_q.pop_front()));
            out_cnt++;
            if (fifo_mode) fifo_cnt++;
        end
        if (fifo_mode && rd_en && cnt0 > 0) fifo_cnt--;
        for (int k = 0; k < NR; k++) begin
            if (in_hs[k]) begin
                exp_q.push_back({2'(k), seq[k]});
                seq[k]++;
                left[k]--;
                hs_req.push_back(k);
                hs_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (dec) begin
            chk("pick_busy", 32'(busy_o), 32'd1);
            chk("pick_valid", 32'(dec_vld[grant_id_o]), 32'd1);
            for (int k = 0; k < NR; k++) begin
                if (dec_vld[k] && (k != int'(grant_id_o))) skip[k]++;
                else skip[k] = 0;
                if (skip[k] > max_skip) max_skip = skip[k];
            end
        end
    endtask

    task automatic set_all(input int n);
        for (int k = 0; k < NR; k++) begin
            en[k]   = 1'b1;
            left[k] = n;
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < NR; k++) en[k] = 1'b0;
        fifo_mode = 1'b0;
        rdy_pct   = 100;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || busy_o); i++) cycle();
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        srst_ni = 1'b0;
        cycle();
        srst_ni = 1'b1;
        exp_q.delete();
        hs_req.delete();
        hs_cyc.delete();
        for (int k = 0; k < NR; k++) skip[k] = 0;
    endtask

    int exp2 [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3};
    int t0;

    initial begin
        for (int k = 0; k < NR; k++) begin
            seq[k]  = '0;
            skip[k] = 0;
        end
        set_all(1000000);
        srst_ni          = 1'b0;
        elem_in_valid_i  = '1;
        elem_in_i        = '0;
        elem_out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle();
        chk("rst_out_data", 32'(elem_out_o), 32'd0);
        chk("rst_out_valid", 32'(elem_out_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_id_o), 32'd0);
        chk("rst_ready", 32'(elem_in_ready_o), 32'd0);
        srst_ni = 1'b1;

        // Round-robin, all valid, FIFO always ready.
        t0 = cyc;
        for (int i = 0; i < 200 && hs_req.size() < 20; i++) cycle();
        chk("rr_count", 32'(hs_req.size() >= 20), 32'd1);
        if (hs_req.size() > 0) chk("rr_first_latency", 32'(hs_cyc[0] - t0), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i < hs_req.size()) chk("rr_grant", 32'(hs_req[i]), 32'((i / 4) % 4));
            if (i > 0 && i < hs_req.size())
                chk("rr_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), (i % 4 == 0) ? 32'd2 : 32'd1);
        end
        drain("rr");
        do_reset();

        // Requester 2 runs dry after two elements.
        set_all(1000000);
        left[2] = 2;
        for (int i = 0; i < 200 && hs_req.size() < 14; i++) cycle();
        chk("early_count", 32'(hs_req.size() >= 14), 32'd1);
        for (int i = 0; i < 14; i++)
            if (i < hs_req.size()) chk("early_grant", 32'(hs_req[i]), 32'(exp2[i]));
        drain("early");
        do_reset();

        // Depth-8 downstream FIFO with reads disabled.
        set_all(1000000);
        fifo_mode = 1'b1;
        fifo_cnt  = 0;
        rd_en     = 1'b0;
        repeat (30) cycle();
        chk("bp_fifo_full", 32'(fifo_cnt), 32'd8);
        chk("bp_accepted", 32'(hs_req.size()), 32'd9);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("bp_ready_low", 32'(elem_in_ready_o), 32'd0);
            chk("bp_grant_stable", 32'(grant_id_o), 32'd2);
            chk("bp_busy", 32'(busy_o), 32'd1);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 200 && hs_req.size() < 13; i++) cycle();
        chk("bp_resume_count", 32'(hs_req.size() >= 13), 32'd1);
        for (int i = 8; i < 13; i++)
            if (i < hs_req.size()) chk("bp_resume_grant", 32'(hs_req[i]), (i < 12) ? 32'd2 : 32'd3);
        drain("bp");
        rd_en = 1'b0;
        do_reset();

        // Reset after the second element of a grant to requester 1.
        for (int k = 0; k < NR; k++) begin
            en[k]   = (k == 1);
            left[k] = 1000000;
        end
        for (int i = 0; i < 20 && hs_req.size() < 2; i++) cycle();
        chk("mb_two_accepted", 32'(hs_req.size()), 32'd2);
        chk("mb_pending_valid", 32'(elem_out_valid_o), 32'd1);
        set_all(1000000);
        do_reset();
        chk("mb_valid_cleared", 32'(elem_out_valid_o), 32'd0);
        chk("mb_busy_cleared", 32'(busy_o), 32'd0);
        chk("mb_ready_cleared", 32'(elem_in_ready_o), 32'd0);
        for (int i = 0; i < 20 && hs_req.size() < 1; i++) cycle();
        chk("mb_restart_count", 32'(hs_req.size()), 32'd1);
        if (hs_req.size() > 0) chk("mb_restart_grant", 32'(hs_req[0]), 32'd0);
        drain("mb");
        do_reset();

        // Random valid (50%) and FIFO ready (70%) over 1000 elements.
        set_all(1000000);
        vld_pct  = 50;
        rdy_pct  = 70;
        out_cnt  = 0;
        max_skip = 0;
        for (int i = 0; i < 20000 && out_cnt < 1000; i++) cycle();
        chk("rand_elements", 32'(out_cnt >= 1000), 32'd1);
        chk("rand_no_starve", 32'(max_skip <= 3 * (MB + 1)), 32'd1);
        vld_pct = 100;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
